avalon_packet_sorter: RTL and testbench

- Avalon-ST packet sorter. Receives one packet of up to MAX_PKT_LEN unsigned words on the sink, sorts it in place with an odd-even transposition network (one pass per cycle), then streams the sorted packet out on the source.
- Generalised successor of the single-buffer receive/send block: parametrised depth, sort direction and backpressure on both sides.
- Sits between packet producers and consumers in the sort datapath.

---
 rtl/avalon_sort_pkg.sv | 34 +++
 rtl/sort_cmp_swap.sv | 28 ++
 rtl/avalon_packet_sorter.sv | 197 +++++++++++++++++++
 tb/tb_avalon_packet_sorter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/avalon_sort_pkg.sv
// Shared types and helpers for the Avalon-ST packet sorter: FSM states,
// counter sizing and the compare-exchange decision.
package avalon_sort_pkg;

    typedef enum logic [1:0] {
        IDLE_S      = 2'd0,
        RECEIVING_S = 2'd1,
        SORTING_S   = 2'd2,
        SENDING_S   = 2'd3
    } state_e;

    // Words are zero-extended to this width before comparison, so DWIDTH <= 64.
    localparam int CMP_MAX_W           = 64;
    localparam int MAX_PKT_LEN_DEFAULT = 16;
    localparam int CNT_W_DEFAULT       = $clog2(MAX_PKT_LEN_DEFAULT + 1);

    function automatic int cnt_width(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    // Strict comparison keeps equal neighbours in place.
    function automatic logic cmp_swap(input logic [CMP_MAX_W-1:0] a,
                                      input logic [CMP_MAX_W-1:0] b,
                                      input logic                 descending);
        logic swap;
        if (descending) begin
            swap = (a < b);
        end else begin
            swap = (a > b);
        end
        return swap;
    endfunction

endpackage

// File: rtl/sort_cmp_swap.sv
// One compare-exchange cell of the odd-even transposition network.
module sort_cmp_swap
    import avalon_sort_pkg::*;
#(
    parameter int DWIDTH     = 10,
    parameter bit DESCENDING = 1'b0
) (
    input  logic [DWIDTH-1:0] a,
    input  logic [DWIDTH-1:0] b,
    output logic [DWIDTH-1:0] a_sorted,
    output logic [DWIDTH-1:0] b_sorted
);

    logic swap_s;

    // Order the pair so a_sorted precedes b_sorted in output order.
    always_comb begin
        swap_s = cmp_swap(CMP_MAX_W'(a), CMP_MAX_W'(b), DESCENDING);
        if (swap_s) begin
            a_sorted = b;
            b_sorted = a;
        end else begin
            a_sorted = a;
            b_sorted = b;
        end
    end

endmodule

// File: rtl/avalon_packet_sorter.sv
// Avalon-ST packet sorter: buffers one packet, sorts it in place with one
// odd-even transposition pass per cycle, then streams it out.
module avalon_packet_sorter
    import avalon_sort_pkg::*;
#(
    parameter int DWIDTH      = 10,
    parameter int MAX_PKT_LEN = MAX_PKT_LEN_DEFAULT,
    parameter bit DESCENDING  = 1'b0
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic [DWIDTH-1:0] snk_data_i,
    input  logic              snk_startofpacket_i,
    input  logic              snk_endofpacket_i,
    input  logic              snk_valid_i,
    output logic              snk_ready_o,
    output logic [DWIDTH-1:0] src_data_o,
    output logic              src_startofpacket_o,
    output logic              src_endofpacket_o,
    output logic              src_valid_o,
    input  logic              src_ready_i,
    output logic              trunc_o
);

    localparam int CW = cnt_width(MAX_PKT_LEN);
    localparam int IW = $clog2(MAX_PKT_LEN);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] LEN_MAX  = CW'(MAX_PKT_LEN);

    state_e            state_r;
    state_e            state_nxt_s;
    logic [CW-1:0]     len_r;
    logic [CW-1:0]     rd_idx_r;
    logic [CW-1:0]     pass_r;
    logic              trunc_r;
    logic              trunc_seen_r;
    logic [DWIDTH-1:0] buf_r [MAX_PKT_LEN];
    logic [DWIDTH-1:0] lo_s  [MAX_PKT_LEN-1];
    logic [DWIDTH-1:0] hi_s  [MAX_PKT_LEN-1];

    logic snk_ready_s, src_valid_s, snk_xfer_s, src_xfer_s;
    logic len_full_s, last_pass_s, last_word_s;

    assign snk_ready_s = (state_r == IDLE_S) || (state_r == RECEIVING_S);
    assign src_valid_s = (state_r == SENDING_S);
    assign snk_xfer_s  = snk_valid_i && snk_ready_s;
    assign src_xfer_s  = src_valid_s && src_ready_i;
    assign len_full_s  = (len_r == LEN_MAX);
    assign last_pass_s = ((pass_r + CNT_ONE) == len_r);
    assign last_word_s = ((rd_idx_r + CNT_ONE) == len_r);

    for (genvar g = 0; g < MAX_PKT_LEN - 1; g++) begin : g_cell
        sort_cmp_swap #(
            .DWIDTH     (DWIDTH),
            .DESCENDING (DESCENDING)
        ) u_cell (
            .a        (buf_r[g]),
            .b        (buf_r[g+1]),
            .a_sorted (lo_s[g]),
            .b_sorted (hi_s[g])
        );
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE_S: begin
                if (snk_xfer_s && snk_startofpacket_i) begin
                    state_nxt_s = snk_endofpacket_i ? SORTING_S : RECEIVING_S;
                end else begin
                    state_nxt_s = IDLE_S;
                end
            end
            RECEIVING_S: begin
                if (snk_xfer_s && snk_endofpacket_i) begin
                    state_nxt_s = SORTING_S;
                end else begin
                    state_nxt_s = RECEIVING_S;
                end
            end
            SORTING_S: begin
                if (last_pass_s) begin
                    state_nxt_s = SENDING_S;
                end else begin
                    state_nxt_s = SORTING_S;
                end
            end
            SENDING_S: begin
                if (src_xfer_s && last_word_s) begin
                    state_nxt_s = IDLE_S;
                end else begin
                    state_nxt_s = SENDING_S;
                end
            end
            default: state_nxt_s = IDLE_S;
        endcase
    end

    // State register, length/pass/read counters and truncation pulse.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_r      <= IDLE_S;
            len_r        <= CNT_ZERO;
            rd_idx_r     <= CNT_ZERO;
            pass_r       <= CNT_ZERO;
            trunc_r      <= 1'b0;
            trunc_seen_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            trunc_r <= 1'b0;
            case (state_r)
                IDLE_S: begin
                    pass_r   <= CNT_ZERO;
                    rd_idx_r <= CNT_ZERO;
                    if (snk_xfer_s && snk_startofpacket_i) begin
                        len_r        <= CNT_ONE;
                        trunc_seen_r <= 1'b0;
                    end
                end
                RECEIVING_S: begin
                    pass_r <= CNT_ZERO;
                    if (snk_xfer_s) begin
                        if (snk_startofpacket_i) begin
                            len_r        <= CNT_ONE;
                            trunc_seen_r <= 1'b0;
                        end else if (!len_full_s) begin
                            len_r <= len_r + CNT_ONE;
                        end else if (!snk_endofpacket_i && !trunc_seen_r) begin
                            trunc_r      <= 1'b1;
                            trunc_seen_r <= 1'b1;
                        end
                    end
                end
                SORTING_S: begin
                    if (last_pass_s) begin
                        pass_r   <= CNT_ZERO;
                        rd_idx_r <= CNT_ZERO;
                    end else begin
                        pass_r <= pass_r + CNT_ONE;
                    end
                end
                SENDING_S: begin
                    if (src_xfer_s) begin
                        if (last_word_s) begin
                            rd_idx_r <= CNT_ZERO;
                            len_r    <= CNT_ZERO;
                        end else begin
                            rd_idx_r <= rd_idx_r + CNT_ONE;
                        end
                    end
                end
                default: pass_r <= CNT_ZERO;
            endcase
        end
    end

    // Packet buffer: sink writes, then one transposition pass per sort cycle.
    always_ff @(posedge clk_i) begin
        case (state_r)
            IDLE_S: begin
                if (snk_xfer_s && snk_startofpacket_i) begin
                    buf_r[0] <= snk_data_i;
                end
            end
            RECEIVING_S: begin
                if (snk_xfer_s) begin
                    if (snk_startofpacket_i) begin
                        buf_r[0] <= snk_data_i;
                    end else if (!len_full_s) begin
                        buf_r[len_r[IW-1:0]] <= snk_data_i;
                    end
                end
            end
            SORTING_S: begin
                // Pair i participates when its parity matches the pass and i+1 < len.
                for (int i = 0; i < MAX_PKT_LEN - 1; i++) begin
                    if ((1'(i) == pass_r[0]) && (CW'(i + 1) < len_r)) begin
                        buf_r[i]   <= lo_s[i];
                        buf_r[i+1] <= hi_s[i];
                    end
                end
            end
            default: begin
            end
        endcase
    end

    assign snk_ready_o         = snk_ready_s;
    assign src_valid_o         = src_valid_s;
    assign src_data_o          = src_valid_s ? buf_r[rd_idx_r[IW-1:0]] : {DWIDTH{1'b0}};
    assign src_startofpacket_o = src_valid_s && (rd_idx_r == CNT_ZERO);
    assign src_endofpacket_o   = src_valid_s && last_word_s;
    assign trunc_o             = trunc_r;

endmodule

// File: tb/tb_avalon_packet_sorter.sv
// Self-checking bench: ascending and descending sorters share one stimulus
// stream and are compared each cycle against a packet-level queue model.
module tb_avalon_packet_sorter;

    localparam int DW   = 10;
    localparam int MAXL = 16;

    logic          clk = 1'b0;
    logic          srst = 1'b1;
    logic [DW-1:0] snk_data = '0;
    logic          snk_sop = 1'b0, snk_eop = 1'b0, snk_valid = 1'b0;
    logic          src_ready = 1'b1;

    logic          a_snk_ready, a_sop, a_eop, a_valid, a_trunc;
    logic          d_snk_ready, d_sop, d_eop, d_valid, d_trunc;
    logic [DW-1:0] a_data, d_data;

    avalon_packet_sorter #(.DWIDTH(DW), .MAX_PKT_LEN(MAXL), .DESCENDING(1'b0)) dut_asc (
        .clk_i(clk), .srst_i(srst),
        .snk_data_i(snk_data), .snk_startofpacket_i(snk_sop), .snk_endofpacket_i(snk_eop),
        .snk_valid_i(snk_valid), .snk_ready_o(a_snk_ready),
        .src_data_o(a_data), .src_startofpacket_o(a_sop), .src_endofpacket_o(a_eop),
        .src_valid_o(a_valid), .src_ready_i(src_ready), .trunc_o(a_trunc));

    avalon_packet_sorter #(.DWIDTH(DW), .MAX_PKT_LEN(MAXL), .DESCENDING(1'b1)) dut_dsc (
        .clk_i(clk), .srst_i(srst),
        .snk_data_i(snk_data), .snk_startofpacket_i(snk_sop), .snk_endofpacket_i(snk_eop),
        .snk_valid_i(snk_valid), .snk_ready_o(d_snk_ready),
        .src_data_o(d_data), .src_startofpacket_o(d_sop), .src_endofpacket_o(d_eop),
        .src_valid_o(d_valid), .src_ready_i(src_ready), .trunc_o(d_trunc));

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    int cyc = 0;
    bit chk_en = 1'b0;
    int rdy_mode = 0;
    int cap_a[$], cap_d[$];
    int n_trunc = 0;
    int t_eop = 0, t_valid = -1;

    // Packet-level model state
    int m_cur[$];
    int exp_a[$], exp_d[$];
    bit m_in_pkt = 1'b0, m_tdone = 1'b0, m_busy = 1'b0, m_trunc = 1'b0;
    int m_delay = 0, m_sent = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic chk_list(input string name, input int got[$], input int exp[$]);
        chk({name, "_len"}, got.size(), exp.size());
        for (int i = 0; i < got.size() && i < exp.size(); i++)
            chk($sformatf("%s[%0d]", name, i), got[i], exp[i]);
    endtask

    function automatic void m_finish();
        exp_a = m_cur; exp_a.sort();
        exp_d = m_cur; exp_d.rsort();
        m_delay  = m_cur.size();
        m_sent   = 0;
        m_busy   = 1'b1;
        m_in_pkt = 1'b0;
    endfunction

    // Reference model: one update per clock edge from the applied inputs.
    initial forever begin
        @(posedge clk);
        cyc++;
        m_trunc = 1'b0;
        if (srst) begin
            m_cur.delete(); exp_a.delete(); exp_d.delete();
            m_in_pkt = 1'b0; m_tdone = 1'b0; m_busy = 1'b0; m_delay = 0; m_sent = 0;
        end else if (m_busy) begin
            if (m_delay > 0) m_delay--;
            else if (src_ready) begin
                void'(exp_a.pop_front()); void'(exp_d.pop_front());
                m_sent++;
                if (exp_a.size() == 0) m_busy = 1'b0;
            end
        end else if (snk_valid) begin
            if (snk_sop) begin
                m_cur.delete(); m_cur.push_back(int'(snk_data));
                m_in_pkt = 1'b1; m_tdone = 1'b0;
                if (snk_eop) m_finish();
            end else if (m_in_pkt) begin
                if (m_cur.size() < MAXL) m_cur.push_back(int'(snk_data));
                else if (!snk_eop && !m_tdone) begin m_trunc = 1'b1; m_tdone = 1'b1; end
                if (snk_eop) m_finish();
            end
        end
    end

    // Per-cycle compare, source-ready driver and output capture.
    initial forever begin
        bit ev;
        @(negedge clk);
        if (chk_en) begin
            ev = m_busy && (m_delay == 0);
            chk("a_snk_ready", a_snk_ready, !m_busy);
            chk("d_snk_ready", d_snk_ready, !m_busy);
            chk("a_valid", a_valid, ev);
            chk("d_valid", d_valid, ev);
            chk("a_trunc", a_trunc, m_trunc);
            chk("d_trunc", d_trunc, m_trunc);
            if (ev) begin
                chk("a_data", a_data, exp_a[0]);
                chk("d_data", d_data, exp_d[0]);
                chk("a_sop", a_sop, m_sent == 0);
                chk("d_sop", d_sop, m_sent == 0);
                chk("a_eop", a_eop, exp_a.size() == 1);
                chk("d_eop", d_eop, exp_d.size() == 1);
            end
        end
        case (rdy_mode)
            0:       src_ready = 1'b1;
            1:       src_ready = ~src_ready;
            default: src_ready = 1'($urandom_range(0, 1));
        endcase
        if (a_valid && src_ready) cap_a.push_back(int'(a_data));
        if (d_valid && src_ready) cap_d.push_back(int'(d_data));
        if (a_trunc) n_trunc++;
        if (a_valid && t_valid < 0) t_valid = cyc;
    end

    task automatic send_word(input int d, input bit sop, input bit eop);
        int n = 0;
        snk_data = DW'(d); snk_sop = sop; snk_eop = eop; snk_valid = 1'b1;
        while (!a_snk_ready && n < 1000) begin @(negedge clk); n++; end
        if (n >= 1000) begin
            n_chk++;
            $display("FAIL snk_timeout: sink ready never seen, required within 1000 cycles");
        end else if (eop) t_eop = cyc;
        @(negedge clk);
        snk_valid = 1'b0; snk_sop = 1'b0; snk_eop = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (m_busy && n < 3000) begin @(negedge clk); n++; end
        if (n >= 3000) begin
            n_chk++;
            $display("FAIL done_timeout: packet still pending, required done within 3000 cycles");
        end
        @(negedge clk);
    endtask

    task automatic clear_caps();
        cap_a.delete(); cap_d.delete(); n_trunc = 0; t_valid = -1;
    endtask

    initial begin
        int e[$], f[$];
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e[$], f[$];
        int len;
        bit sop;
        repeat (3) @(negedge clk);
        srst = 1'b0;
        chk("rst_snk_ready", a_snk_ready, 1);
        chk("rst_valid", a_valid, 0);
        chk("rst_data", a_data, 0);
        chk("rst_trunc", a_trunc, 0);
        chk_en = 1'b1;

        // Ascending basic + latency
        clear_caps(); rdy_mode = 0;
        send_word(5, 1, 0); send_word(3, 0, 0); send_word(9, 0, 0);
        send_word(1, 0, 0); send_word(7, 0, 1);
        wait_done();
        e = {1, 3, 5, 7, 9}; chk_list("t1_asc", cap_a, e);
        chk("t1_latency", t_valid - t_eop, 6);

        // Descending with alternating backpressure
        clear_caps(); rdy_mode = 1;
        send_word(2, 1, 0); send_word(8, 0, 0); send_word(8, 0, 0); send_word(4, 0, 1);
        wait_done();
        e = {8, 8, 4, 2}; chk_list("t2_dsc", cap_d, e);
        e = {2, 4, 8, 8}; chk_list("t2_asc", cap_a, e);

        // Single word
        clear_caps(); rdy_mode = 0;
        send_word(10'h3FF, 1, 1);
        wait_done();
        e = {1023}; chk_list("t3_asc", cap_a, e); chk_list("t3_dsc", cap_d, e);
        chk("t3_ready", a_snk_ready, 1);

        // Truncation: 18 words 17..0
        clear_caps();
        for (int v = 17; v >= 0; v--) send_word(v, v == 17, v == 0);
        wait_done();
        chk("t4_trunc_pulses", n_trunc, 1);
        e.delete(); for (int v = 2; v <= 17; v++) e.push_back(v);
        chk_list("t4_asc", cap_a, e);

        // Restart, then a stray non-sop word
        clear_caps();
        send_word(9, 1, 0); send_word(6, 0, 0); send_word(4, 1, 0); send_word(1, 0, 1);
        wait_done();
        e = {1, 4}; chk_list("t5_asc", cap_a, e);
        clear_caps();
        send_word(5, 0, 0);
        repeat (30) @(negedge clk);
        chk("t5_stray_out", cap_a.size(), 0);

        // Reset during sorting
        send_word(10, 1, 0); send_word(30, 0, 0); send_word(20, 0, 0);
        send_word(50, 0, 0); send_word(40, 0, 1);
        @(negedge clk);
        srst = 1'b1;
        @(negedge clk);
        srst = 1'b0;
        chk("t6_ready", a_snk_ready, 1); chk("t6_valid", a_valid, 0);
        chk("t6_data", a_data, 0); chk("t6_sop", a_sop, 0);
        chk("t6_eop", a_eop, 0); chk("t6_trunc", a_trunc, 0);
        chk("t6_d_valid", d_valid, 0); chk("t6_d_data", d_data, 0);
        clear_caps();
        send_word(3, 1, 0); send_word(2, 0, 0); send_word(1, 0, 1);
        wait_done();
        e = {1, 2, 3}; chk_list("t6_asc", cap_a, e);
        f = {3, 2, 1}; chk_list("t6_dsc", cap_d, f);

        // Randomized packets with random backpressure, restarts and stray words
        rdy_mode = 2;
        for (int p = 0; p < 40; p++) begin
            if ($urandom_range(0, 7) == 0) send_word($urandom_range(0, 1023), 0, 0);
            len = $urandom_range(1, 20);
            for (int i = 0; i < len; i++) begin
                sop = (i == 0) || ($urandom_range(0, 11) == 0);
                send_word($urandom_range(0, 1023), sop, i == len - 1);
            end
        end
        wait_done();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
